vctr_fetch_engine: RTL and testbench

Downstream consumer of the address FIFO filled by the driver control block. While `active_program` is high it pops start addresses from the address FIFO and issues `BURST_LEN` single-word memory reads per address. It pushes the returned words, optionally byte-swapped, into the vector FIFO. It reports the per-burst cycle count and the running total of vector words written, both read back through the driver register map (0x104, 0x114).

---
 rtl/vctr_fetch_engine.sv | 162 ++++++++++++++++
 tb/tb_vctr_fetch_engine.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vctr_fetch_engine.sv
// vctr_fetch_engine: pops burst start addresses, reads BURST_LEN words per address and
// writes them to the vector FIFO. Define VCTR_FETCH_BYTE_SWAP_EN to enable word byte reversal.
module vctr_fetch_engine #(
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active_program,
    input  logic        program_start,
    input  logic        vector_byte_swap,
    input  logic        addr_fifo_empty,
    input  logic [31:0] addr_fifo_dout,
    output logic        addr_fifo_rd,
    input  logic        vector_fifo_full,
    output logic        vctr_fifo_wr,
    output logic [31:0] vctr_fifo_din,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_gnt,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [15:0] addr_cycle_cnt,
    output logic [31:0] total_vctr_fifo_words_written,
    output logic        fetch_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LOAD, S_REQ, S_WAIT, S_PUSH
    } state_t;

    localparam logic [8:0]  BURST_LEN_C = 9'(BURST_LEN);
    localparam logic [31:0] STRIDE_C    = 32'(ADDR_STRIDE);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] total_q, total_d;
    logic        ps_q;
    logic        ps_rise;
    logic        burst_done;
    logic        in_burst;
    logic [31:0] rd_word;

`ifdef VCTR_FETCH_BYTE_SWAP_EN
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign rd_word = vector_byte_swap ? byte_swap(mem_rd_data) : mem_rd_data;
`else
    logic unused_swap;
    assign unused_swap = vector_byte_swap;
    assign rd_word     = mem_rd_data;
`endif

    assign ps_rise    = program_start && !ps_q;
    assign burst_done = ({1'b0, beat_q} + 9'd1) == BURST_LEN_C;
    assign in_burst   = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_PUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (active_program && !addr_fifo_empty) state_d = S_POP;
            S_POP:  state_d = S_LOAD;
            S_LOAD: state_d = S_REQ;
            S_REQ: begin
                if (mem_rd_req && mem_rd_gnt) begin
                    state_d = S_WAIT;
                end else if (!active_program) begin
                    state_d = S_IDLE;
                end
            end
            // A granted read always completes so the returned word is never lost.
            S_WAIT: if (mem_rd_valid) state_d = S_PUSH;
            S_PUSH: begin
                if (burst_done) begin
                    state_d = (active_program && !addr_fifo_empty) ? S_POP : S_IDLE;
                end else begin
                    state_d = active_program ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is gated by FIFO space so a granted word always has room when it returns.
    always_comb begin
        addr_fifo_rd = 1'b0;
        mem_rd_req   = 1'b0;
        vctr_fifo_wr = 1'b0;
        fetch_busy   = (state_q != S_IDLE);
        case (state_q)
            S_POP:   addr_fifo_rd = 1'b1;
            S_REQ:   mem_rd_req   = !vector_fifo_full;
            S_PUSH:  vctr_fifo_wr = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        case (state_q)
            S_LOAD: begin
                addr_d = addr_fifo_dout;
                beat_d = '0;
                cnt_d  = '0;
            end
            S_WAIT: if (mem_rd_valid) data_d = rd_word;
            S_PUSH: begin
                addr_d = addr_q + STRIDE_C;
                beat_d = beat_q + 8'd1;
            end
            default: ;
        endcase
        if (in_burst && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        // A start edge coinciding with a write counts that write as the first of the run.
        if (ps_rise) begin
            total_d = (state_q == S_PUSH) ? 32'd1 : 32'd0;
        end else if (state_q == S_PUSH) begin
            total_d = total_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            ps_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            ps_q    <= program_start;
        end
    end

    assign mem_rd_addr                   = addr_q;
    assign vctr_fifo_din                 = data_q;
    assign addr_cycle_cnt                = cnt_q;
    assign total_vctr_fifo_words_written = total_q;

endmodule

// File: tb/tb_vctr_fetch_engine.sv
// Directed bench for vctr_fetch_engine with small address-FIFO and memory responders.
module tb_vctr_fetch_engine;

    logic        clk;
    logic        reset;
    logic        active_program;
    logic        program_start;
    logic        vector_byte_swap;
    logic        addr_fifo_empty;
    logic [31:0] addr_fifo_dout;
    logic        addr_fifo_rd;
    logic        vector_fifo_full;
    logic        vctr_fifo_wr;
    logic [31:0] vctr_fifo_din;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_gnt;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [15:0] addr_cycle_cnt;
    logic [31:0] total_vctr_fifo_words_written;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    logic        tb_init;
    logic [31:0] addr_mem [16];
    logic [3:0]  af_wr;
    logic [3:0]  af_rd;
    logic        gnt_en;
    logic        auto_mem;
    logic        man_valid;
    logic [31:0] man_data;
    logic        mdl_valid;
    logic [31:0] mdl_data;
    logic [31:0] mem_xor;
    logic [31:0] wr_q[$];
    logic [31:0] rd_q[$];
    bit          bad_pop;
    bit          bad_wr;
    logic [31:0] swap_exp;
    logic [31:0] swap_last_exp;

    vctr_fetch_engine #(.BURST_LEN(4), .ADDR_STRIDE(4)) dut (
        .clk                           (clk),
        .reset                         (reset),
        .active_program                (active_program),
        .program_start                 (program_start),
        .vector_byte_swap              (vector_byte_swap),
        .addr_fifo_empty               (addr_fifo_empty),
        .addr_fifo_dout                (addr_fifo_dout),
        .addr_fifo_rd                  (addr_fifo_rd),
        .vector_fifo_full              (vector_fifo_full),
        .vctr_fifo_wr                  (vctr_fifo_wr),
        .vctr_fifo_din                 (vctr_fifo_din),
        .mem_rd_req                    (mem_rd_req),
        .mem_rd_addr                   (mem_rd_addr),
        .mem_rd_gnt                    (mem_rd_gnt),
        .mem_rd_valid                  (mem_rd_valid),
        .mem_rd_data                   (mem_rd_data),
        .addr_cycle_cnt                (addr_cycle_cnt),
        .total_vctr_fifo_words_written (total_vctr_fifo_words_written),
        .fetch_busy                    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address FIFO: data appears the cycle after the pop strobe.
    assign addr_fifo_empty = (af_rd == af_wr);
    always @(posedge clk) begin
        if (tb_init) begin
            af_rd          <= '0;
            addr_fifo_dout <= '0;
        end else if (addr_fifo_rd) begin
            addr_fifo_dout <= addr_mem[af_rd];
            af_rd          <= af_rd + 4'd1;
        end
    end

    // Memory: grant in the request cycle, data (address ^ mem_xor) one cycle later.
    assign mem_rd_gnt   = mem_rd_req && gnt_en;
    assign mem_rd_valid = auto_mem ? mdl_valid : man_valid;
    assign mem_rd_data  = auto_mem ? mdl_data : man_data;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_valid <= 1'b0;
            mdl_data  <= '0;
        end else begin
            mdl_valid <= mem_rd_req && mem_rd_gnt;
            mdl_data  <= mem_rd_addr ^ mem_xor;
        end
    end

    always @(posedge clk) begin
        if (mem_rd_req && mem_rd_gnt) rd_q.push_back(mem_rd_addr);
        if (vctr_fifo_wr) wr_q.push_back(vctr_fifo_din);
        if (addr_fifo_rd && addr_fifo_empty) bad_pop <= 1'b1;
        if (vctr_fifo_wr && vector_fifo_full) bad_wr <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_addr(input logic [31:0] a);
        addr_mem[af_wr] = a;
        af_wr = af_wr + 4'd1;
    endtask

    initial begin
        reset            = 1'b1;
        tb_init          = 1'b1;
        active_program   = 1'b0;
        program_start    = 1'b0;
        vector_byte_swap = 1'b0;
        vector_fifo_full = 1'b0;
        gnt_en           = 1'b1;
        auto_mem         = 1'b1;
        man_valid        = 1'b0;
        man_data         = '0;
        mem_xor          = 32'hDEAD_0000;
        af_wr            = '0;
`ifdef VCTR_FETCH_BYTE_SWAP_EN
        swap_exp      = 32'h4433_2211;
        swap_last_exp = 32'h5033_2211;
`else
        swap_exp      = 32'h1122_3344;
        swap_last_exp = 32'h1122_3350;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, fetch_busy}, 32'd0);
        check("rst_pop", {31'b0, addr_fifo_rd}, 32'd0);
        check("rst_req", {31'b0, mem_rd_req}, 32'd0);
        check("rst_wr", {31'b0, vctr_fifo_wr}, 32'd0);
        check("rst_addr", mem_rd_addr, 32'd0);
        check("rst_din", vctr_fifo_din, 32'd0);
        check("rst_total", total_vctr_fifo_words_written, 32'd0);
        check("rst_cnt", {16'b0, addr_cycle_cnt}, 32'd0);
        tb_init = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // Single address, 4 beats at 0x1000.
        push_addr(32'h0000_1000);
        active_program = 1'b1;
        check("t1_idle_n", {31'b0, fetch_busy}, 32'd0);
        @(negedge clk);
        check("t1_pop", {31'b0, addr_fifo_rd}, 32'd1);
        @(negedge clk);
        check("t1_load_req", {31'b0, mem_rd_req}, 32'd0);
        @(negedge clk);
        check("t1_req", {31'b0, mem_rd_req}, 32'd1);
        check("t1_addr0", mem_rd_addr, 32'h0000_1000);
        repeat (2) @(negedge clk);
        check("t1_wr0", {31'b0, vctr_fifo_wr}, 32'd1);
        check("t1_din0", vctr_fifo_din, 32'hDEAD_1000);
        repeat (10) @(negedge clk);
        check("t1_busy_end", {31'b0, fetch_busy}, 32'd0);
        check("t1_total", total_vctr_fifo_words_written, 32'd4);
        check("t1_cnt", {16'b0, addr_cycle_cnt}, 32'd12);
        check("t1_nwr", 32'(wr_q.size()), 32'd4);
        check("t1_rd1", rd_q[1], 32'h0000_1004);
        check("t1_rd2", rd_q[2], 32'h0000_1008);
        check("t1_rd3", rd_q[3], 32'h0000_100C);
        check("t1_wr3", wr_q[3], 32'hDEAD_100C);

        // Backpressure: vector FIFO full for the first 10 REQ cycles.
        @(negedge clk);
        push_addr(32'h0000_2000);
        vector_fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t2_req_low", {31'b0, mem_rd_req}, 32'd0);
            @(negedge clk);
        end
        vector_fifo_full = 1'b0;
        #1;
        check("t2_req_rise", {31'b0, mem_rd_req}, 32'd1);
        check("t2_addr", mem_rd_addr, 32'h0000_2000);
        repeat (2) @(negedge clk);
        check("t2_wr0", {31'b0, vctr_fifo_wr}, 32'd1);
        check("t2_din0", vctr_fifo_din, 32'hDEAD_2000);
        repeat (10) @(negedge clk);
        check("t2_busy_end", {31'b0, fetch_busy}, 32'd0);
        check("t2_total", total_vctr_fifo_words_written, 32'd8);
        check("t2_cnt", {16'b0, addr_cycle_cnt}, 32'd22);
        check("t2_nwr", 32'(wr_q.size()), 32'd8);
        check("t2_wr7", wr_q[7], 32'hDEAD_200C);

        // Abort: active_program drops in WAIT of beat 2.
        @(negedge clk);
        push_addr(32'h0000_3000);
        repeat (7) @(negedge clk);
        active_program = 1'b0;
        @(negedge clk);
        check("t3_wr1", {31'b0, vctr_fifo_wr}, 32'd1);
        check("t3_din1", vctr_fifo_din, 32'hDEAD_3004);
        @(negedge clk);
        check("t3_busy", {31'b0, fetch_busy}, 32'd0);
        check("t3_total", total_vctr_fifo_words_written, 32'd10);
        check("t3_cnt", {16'b0, addr_cycle_cnt}, 32'd6);
        repeat (5) @(negedge clk);
        check("t3_no_req", {31'b0, mem_rd_req}, 32'd0);
        check("t3_nrd", 32'(rd_q.size()), 32'd10);
        check("t3_cnt_hold", {16'b0, addr_cycle_cnt}, 32'd6);

        // Abort in REQ before any grant.
        gnt_en = 1'b0;
        active_program = 1'b1;
        push_addr(32'h0000_5000);
        repeat (4) @(negedge clk);
        check("t3b_req_held", {31'b0, mem_rd_req}, 32'd1);
        check("t3b_addr", mem_rd_addr, 32'h0000_5000);
        active_program = 1'b0;
        @(negedge clk);
        check("t3b_busy", {31'b0, fetch_busy}, 32'd0);
        check("t3b_req", {31'b0, mem_rd_req}, 32'd0);
        check("t3b_cnt", {16'b0, addr_cycle_cnt}, 32'd2);
        check("t3b_nrd", 32'(rd_q.size()), 32'd10);
        gnt_en = 1'b1;

        // Wrap at 2^32 and program_start rise coinciding with a PUSH.
        @(negedge clk);
        push_addr(32'hFFFF_FFFC);
        active_program = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_addr0", mem_rd_addr, 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        check("t4_din0", vctr_fifo_din, 32'h2152_FFFC);
        @(negedge clk);
        check("t4_req1", {31'b0, mem_rd_req}, 32'd1);
        check("t4_addr_wrap", mem_rd_addr, 32'h0000_0000);
        @(negedge clk);
        active_program = 1'b0;
        @(negedge clk);
        check("t4_wr1", {31'b0, vctr_fifo_wr}, 32'd1);
        check("t4_din1", vctr_fifo_din, 32'hDEAD_0000);
        program_start = 1'b1;
        @(negedge clk);
        check("t4_total_clr", total_vctr_fifo_words_written, 32'd1);
        check("t4_busy", {31'b0, fetch_busy}, 32'd0);

        // Byte swap on the returned word.
        mem_xor = 32'h0000_0000;
        vector_byte_swap = 1'b1;
        push_addr(32'h1122_3344);
        active_program = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_wr0", {31'b0, vctr_fifo_wr}, 32'd1);
        check("t5_din0", vctr_fifo_din, swap_exp);
        repeat (10) @(negedge clk);
        check("t5_busy", {31'b0, fetch_busy}, 32'd0);
        check("t5_total", total_vctr_fifo_words_written, 32'd5);
        check("t5_last", wr_q[15], swap_last_exp);
        vector_byte_swap = 1'b0;
        mem_xor = 32'hDEAD_0000;

        // Asynchronous reset in WAIT, then a stray valid after release.
        auto_mem = 1'b0;
        push_addr(32'h0000_6000);
        repeat (4) @(negedge clk);
        check("t6_busy_wait", {31'b0, fetch_busy}, 32'd1);
        check("t6_req_wait", {31'b0, mem_rd_req}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", {31'b0, fetch_busy}, 32'd0);
        check("t6_rst_addr", mem_rd_addr, 32'd0);
        check("t6_rst_total", total_vctr_fifo_words_written, 32'd0);
        check("t6_rst_cnt", {16'b0, addr_cycle_cnt}, 32'd0);
        check("t6_rst_din", vctr_fifo_din, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        man_data  = 32'h0BAD_0BAD;
        man_valid = 1'b1;
        @(negedge clk);
        check("t6_no_wr", {31'b0, vctr_fifo_wr}, 32'd0);
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_nwr", 32'(wr_q.size()), 32'd16);
        check("t6_total", total_vctr_fifo_words_written, 32'd0);
        check("t6_busy", {31'b0, fetch_busy}, 32'd0);
        check("t6_nrd", 32'(rd_q.size()), 32'd17);

        check("no_empty_pop", {31'b0, bad_pop}, 32'd0);
        check("no_full_write", {31'b0, bad_wr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
